// File: rtl/ti_sbox_pkg.sv
// Shared types for the 4-share threshold-implementation S-box round-1/round-2 pipeline.
// Optional remasking of the captured shares is enabled with TI_SBOX_REMASK_EN.
package ti_sbox_pkg;

  localparam int NSHARES_DEF = 4;
  localparam int NBITS_DEF   = 4;

  typedef logic [NBITS_DEF-1:0]   share_t;
  typedef logic [2*NBITS_DEF-1:0] idx_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/ti_sbox_r1r2_pipe_remask.sv
// Sum-preserving share remask: each fresh random nibble is XORed into two adjacent shares,
// so it cancels in the unshared value. Purely combinational; used only with TI_SBOX_REMASK_EN.
module ti_share_remask
  import ti_sbox_pkg::*;
#(
  parameter int NSHARES = NSHARES_DEF,
  parameter int NBITS   = NBITS_DEF
) (
  input  logic [NSHARES*NBITS-1:0]     shares,
  input  logic [(NSHARES-1)*NBITS-1:0] rnd,
  output logic [NSHARES*NBITS-1:0]     masked
);

  for (genvar i = 0; i < NSHARES; i++) begin : g_share
    if (i == 0) begin : g_first
      assign masked[i*NBITS +: NBITS] = shares[i*NBITS +: NBITS] ^ rnd[i*NBITS +: NBITS];
    end else if (i == NSHARES-1) begin : g_last
      assign masked[i*NBITS +: NBITS] = shares[i*NBITS +: NBITS] ^ rnd[(i-1)*NBITS +: NBITS];
    end else begin : g_mid
      assign masked[i*NBITS +: NBITS] = shares[i*NBITS +: NBITS]
                                        ^ rnd[(i-1)*NBITS +: NBITS]
                                        ^ rnd[i*NBITS +: NBITS];
    end
  end

endmodule

// File: rtl/ti_sbox_r1r2_pipe.sv
// Glitch-barrier register stage between TI S-box rounds with a 2-entry skid buffer; 1-cycle latency,
// s_ready registered (drops only when the skid is full). Remask option: TI_SBOX_REMASK_EN.
module ti_sbox_r1r2_pipe
  import ti_sbox_pkg::*;
#(
  parameter int NSHARES = NSHARES_DEF,
  parameter int NBITS   = NBITS_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [NSHARES*NBITS-1:0]       s_shares,
`ifdef TI_SBOX_REMASK_EN
  input  logic [(NSHARES-1)*NBITS-1:0]   rnd,
`endif
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NSHARES*2*NBITS-1:0]     m_idx,
  output logic [CNT_W-1:0]               txn_cnt
);

  localparam int SW = NSHARES*NBITS;

  state_t        state;
  logic [SW-1:0] din;
  logic [SW-1:0] main_q;
  logic [SW-1:0] skid_q;
  logic          accept;
  logic          pop;

`ifdef TI_SBOX_REMASK_EN
  ti_share_remask #(
    .NSHARES (NSHARES),
    .NBITS   (NBITS)
  ) u_remask (
    .shares (s_shares),
    .rnd    (rnd),
    .masked (din)
  );
`else
  assign din = s_shares;
`endif

  assign accept = s_valid && s_ready;
  assign pop    = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
      txn_cnt <= '0;
    end else begin
      // Counted even when a flush discards the data in the same cycle.
      if (accept)
        txn_cnt <= txn_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

      if (flush) begin
        state   <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        m_valid <= 1'b0;
        s_ready <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            s_ready <= 1'b1;
            if (accept) begin
              main_q  <= din;
              m_valid <= 1'b1;
              state   <= ONE;
            end
          end
          ONE: begin
            if (accept && pop) begin
              main_q <= din;
            end else if (accept) begin
              skid_q  <= din;
              s_ready <= 1'b0;
              state   <= TWO;
            end else if (pop) begin
              m_valid <= 1'b0;
              state   <= EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              main_q  <= skid_q;
              s_ready <= 1'b1;
              state   <= ONE;
            end
          end
          default: begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= EMPTY;
          end
        endcase
      end
    end
  end

  // Index j pairs share j with its cyclic neighbour; only register bits feed m_idx.
  for (genvar j = 0; j < NSHARES; j++) begin : g_idx
    assign m_idx[j*2*NBITS +: 2*NBITS] = {main_q[((j+1)%NSHARES)*NBITS +: NBITS],
                                          main_q[j*NBITS +: NBITS]};
  end

endmodule

// File: tb/tb_ti_sbox_r1r2_pipe.sv
// Bench for ti_sbox_r1r2_pipe: queue-based FIFO reference model, directed scenarios plus random traffic.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_ti_sbox_r1r2_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] s_shares = '0;
  logic [11:0] rnd = '0;

  logic        s_ready, m_valid;
  logic [31:0] m_idx;
  logic [15:0] txn_cnt;
  logic        w_s_ready, w_m_valid;
  logic [31:0] w_m_idx;
  logic [3:0]  w_cnt;

  int          vectors = 0;
  int          errors = 0;
  logic [15:0] q[$];
  bit          exp_rdy = 1'b0;
  logic [15:0] exp_cnt = '0;

  ti_sbox_r1r2_pipe #(.NSHARES(4), .NBITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_shares(s_shares),
`ifdef TI_SBOX_REMASK_EN
    .rnd(rnd),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .txn_cnt(txn_cnt)
  );

  ti_sbox_r1r2_pipe #(.NSHARES(4), .NBITS(4), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(w_s_ready),
    .s_shares(s_shares),
`ifdef TI_SBOX_REMASK_EN
    .rnd(rnd),
`endif
    .m_valid(w_m_valid), .m_ready(m_ready), .m_idx(w_m_idx), .txn_cnt(w_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_idx(input logic [15:0] sh);
    logic [3:0]  s[4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) s[i] = sh[i*4 +: 4];
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = {s[(j+1)%4], s[j]};
    return r;
  endfunction

  // Random nibble k touches shares k and k+1, so the unshared sum is unchanged.
  function automatic logic [15:0] model_share(input logic [15:0] sh, input logic [11:0] r);
    logic [15:0] o;
    o = sh;
`ifdef TI_SBOX_REMASK_EN
    for (int k = 0; k < 3; k++) begin
      o[k*4 +: 4]     = o[k*4 +: 4] ^ r[k*4 +: 4];
      o[(k+1)*4 +: 4] = o[(k+1)*4 +: 4] ^ r[k*4 +: 4];
    end
`else
    if (r == 12'hFFF) o = sh;
`endif
    return o;
  endfunction

  // Advance one clock edge and update the reference model; returns at the following negedge.
  task automatic tick();
    bit acc, pp;
    acc = s_valid && exp_rdy;
    pp  = (q.size() > 0) && m_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(model_share(s_shares, rnd));
    end
    if (acc) exp_cnt = exp_cnt + 16'd1;
    exp_rdy = (q.size() < 2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    q.delete(); exp_rdy = 1'b0; exp_cnt = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_stage();
    s_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    vectors++; if (txn_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %h want 0", txn_cnt); end
    rst = 1'b0;
    tick();
    vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %b want 1", s_ready); end
    // Store two entries, then reset in the middle of the backpressured transfer.
    m_ready = 1'b0; s_valid = 1'b1;
    s_shares = 16'h1234; tick();
    s_shares = 16'h5678; tick();
    s_valid = 1'b0;
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL two_full_ready: got %b want 0", s_ready); end
    rst = 1'b1; q.delete(); exp_rdy = 1'b0; exp_cnt = '0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    vectors++; if (txn_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %h want 0", txn_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early: got %b want 0", s_ready); end
    @(negedge clk);
    tick();
    vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", s_ready); end
    exp_rdy = 1'b1;
  endtask

  task automatic test_single();
    rnd = '0; m_ready = 1'b1; s_valid = 1'b1; s_shares = 16'h4321;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid); end
    vectors++; if (m_idx !== 32'h14433221) begin errors++; $display("FAIL single_idx: got %h want 14433221", m_idx); end
    vectors++; if (txn_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %h want 1", txn_cnt); end
    tick();
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    bit          will_acc;
    rnd = '0; m_ready = 1'b0; s_valid = 1'b1;
    s_shares = 16'h0001; tick();
    s_shares = 16'h0002; tick();
    s_shares = 16'h0003; tick();
    vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", s_ready); end
    vectors++; if (m_idx !== exp_idx(16'h0001)) begin errors++; $display("FAIL bp_hold_idx: got %h want %h", m_idx, exp_idx(16'h0001)); end
    tick();
    vectors++; if (m_valid !== 1'b1 || m_idx !== exp_idx(16'h0001)) begin errors++; $display("FAIL bp_stable: got %b/%h want 1/%h", m_valid, m_idx, exp_idx(16'h0001)); end
    m_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (m_valid && m_ready) got.push_back(m_idx);
      will_acc = s_valid && exp_rdy;
      tick();
      if (will_acc) s_valid = 1'b0;
    end
    vectors++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      vectors++;
      if (got[k] !== exp_idx(16'(k+1))) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], exp_idx(16'(k+1))); end
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    m_ready = 1'b0; s_valid = 1'b1;
    s_shares = 16'h1111; tick();
    s_shares = 16'h2222; tick();
    c0 = exp_cnt;
    s_shares = 16'hAAAA; flush = 1'b1; tick();
    flush = 1'b0; s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b want 0", m_valid); end
    vectors++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush2_ready: got %b want 1", s_ready); end
    vectors++; if (txn_cnt !== c0) begin errors++; $display("FAIL flush2_cnt: got %h want %h", txn_cnt, c0); end
    // Flush coinciding with an accepted beat: data dropped, beat still counted.
    s_valid = 1'b1; s_shares = 16'h5555; tick();
    c0 = exp_cnt;
    s_shares = 16'hAAAA; flush = 1'b1; tick();
    flush = 1'b0; s_valid = 1'b0;
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush1_valid: got %b want 0", m_valid); end
    vectors++; if (txn_cnt !== c0 + 16'd1) begin errors++; $display("FAIL flush1_cnt: got %h want %h", txn_cnt, c0 + 16'd1); end
  endtask

  task automatic test_wrap();
    int  n;
    bit  will_acc;
    do_reset();
    n = 0; m_ready = 1'b1; s_valid = 1'b1;
    for (int c = 0; c < 60 && n < 17; c++) begin
      s_shares = 16'($urandom);
      will_acc = s_valid && exp_rdy;
      tick();
      if (will_acc) n++;
    end
    s_valid = 1'b0;
    vectors++; if (w_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %h want 1", w_cnt); end
    vectors++; if (txn_cnt !== 16'd17) begin errors++; $display("FAIL wrap_cnt16: got %h want 11", txn_cnt); end
    clear_stage();
  endtask

`ifdef TI_SBOX_REMASK_EN
  task automatic test_remask();
    logic [3:0] sum;
    rnd = 12'hFFF; s_shares = 16'h0000; s_valid = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    vectors++; if (m_idx !== 32'hFFF0000F) begin errors++; $display("FAIL remask_idx: got %h want fff0000f", m_idx); end
    sum = m_idx[3:0] ^ m_idx[11:8] ^ m_idx[19:16] ^ m_idx[27:24];
    vectors++; if (sum !== 4'h0) begin errors++; $display("FAIL remask_sum: got %h want 0", sum); end
    clear_stage();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      s_shares = 16'($urandom);
      rnd      = 12'($urandom);
      tick();
      vectors++; if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, m_valid, q.size() > 0); end
      vectors++; if (w_m_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_wvalid@%0d: got %b want %b", c, w_m_valid, q.size() > 0); end
      vectors++; if (s_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, s_ready, exp_rdy); end
      vectors++; if (txn_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %h want %h", c, txn_cnt, exp_cnt); end
      vectors++; if (w_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL rnd_wcnt@%0d: got %h want %h", c, w_cnt, exp_cnt[3:0]); end
      if (q.size() > 0) begin
        vectors++;
        if (m_idx !== exp_idx(q[0])) begin errors++; $display("FAIL rnd_idx@%0d: got %h want %h", c, m_idx, exp_idx(q[0])); end
      end
    end
    flush = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_wrap();
`ifdef TI_SBOX_REMASK_EN
    test_remask();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
